// File: rtl/gcd_pkg.sv
// gcd_pkg: shared types and constants for the GCD engine.
//   state_t  : controller states (IDLE, ALIGN, CALC, DONE)
//   MODE_SUB : subtractive Euclid iteration
//   MODE_BIN : binary (Stein) shift/subtract iteration
package gcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        CALC  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int MODE_SUB = 0;
    localparam int MODE_BIN = 1;

endpackage

// File: rtl/gcd_if.sv
// gcd_if: operand/result handshake bundle for gcd_unit.
//   in_valid/in_ready/in_a/in_b     : operand pair request port
//   out_valid/out_ready/out_gcd     : result port
//   busy                            : engine is iterating
//   out_cycles                      : iteration count (only with GCD_CYCLE_COUNT_EN)
// Modports: master = request source / result sink, slave = gcd_unit.
interface gcd_if #(
    parameter int WIDTH = 16
`ifdef GCD_CYCLE_COUNT_EN
    , parameter int CNT_W = 17
`endif
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_gcd;
    logic             busy;
`ifdef GCD_CYCLE_COUNT_EN
    logic [CNT_W-1:0] out_cycles;
`endif

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_gcd, busy
`ifdef GCD_CYCLE_COUNT_EN
        , input out_cycles
`endif
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_gcd, busy
`ifdef GCD_CYCLE_COUNT_EN
        , output out_cycles
`endif
    );

endinterface

// File: rtl/gcd_datapath.sv
// gcd_datapath: x/y operand registers, shift count k and next-value logic.
//   clk, rst     : clock, async active-high reset
//   load_i       : capture a_i/b_i, clear k
//   align_i      : halve both operands, k++ (binary mode common factor of 2)
//   step_i       : one reduction step (subtractive or binary per MODE)
//   a_i, b_i     : operands to load
//   eq_o         : x == y
//   both_even_o  : x and y both even
//   result_o     : x << k
module gcd_datapath
    import gcd_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int MODE  = MODE_SUB
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             align_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             eq_o,
    output logic             both_even_o,
    output logic [WIDTH-1:0] result_o
);
    localparam int K_W = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] x_q, x_d, y_q, y_d;
    logic [K_W-1:0]   k_q, k_d;
    logic             lt;

    assign eq_o        = (x_q == y_q);
    assign lt          = (x_q < y_q);
    assign both_even_o = ~x_q[0] & ~y_q[0];
    assign result_o    = x_q << k_q;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        k_d = k_q;
        if (load_i) begin
            x_d = a_i;
            y_d = b_i;
            k_d = '0;
        end else if (align_i) begin
            x_d = x_q >> 1;
            y_d = y_q >> 1;
            k_d = k_q + K_W'(1);
        end else if (step_i) begin
            if (MODE == MODE_BIN) begin
                // After one operand turns odd, odd-odd differences are even,
                // so the halve after subtract never drops a common factor.
                if (!x_q[0])      x_d = x_q >> 1;
                else if (!y_q[0]) y_d = y_q >> 1;
                else if (lt)      y_d = (y_q - x_q) >> 1;
                else              x_d = (x_q - y_q) >> 1;
            end else begin
                if (lt) y_d = y_q - x_q;
                else    x_d = x_q - y_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
            k_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
            k_q <= k_d;
        end
    end

endmodule

// File: rtl/gcd_unit.sv
// gcd_unit: GCD engine with valid/ready operand and result ports.
//   clk  : clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : gcd_if.slave (in_valid/in_ready/in_a/in_b, out_valid/out_ready/
//          out_gcd, busy, out_cycles when GCD_CYCLE_COUNT_EN is defined)
// Parameters: WIDTH operand width, MODE 0 subtractive / 1 binary,
//   CNT_W iteration counter width (only with GCD_CYCLE_COUNT_EN).
// Optional feature macro: GCD_CYCLE_COUNT_EN adds the saturating
// ALIGN+CALC cycle counter on out_cycles.
module gcd_unit
    import gcd_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int MODE  = MODE_SUB
`ifdef GCD_CYCLE_COUNT_EN
    , parameter int CNT_W = 17
`endif
) (
    input  logic clk,
    input  logic rst,
    gcd_if.slave bus
);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             load, align, step;
    logic             eq, both_even;
    logic [WIDTH-1:0] dp_result;

    gcd_datapath #(.WIDTH(WIDTH), .MODE(MODE)) u_dp (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load),
        .align_i    (align),
        .step_i     (step),
        .a_i        (bus.in_a),
        .b_i        (bus.in_b),
        .eq_o       (eq),
        .both_even_o(both_even),
        .result_o   (dp_result)
    );

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        load     = 1'b0;
        align    = 1'b0;
        step     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    load = 1'b1;
                    // A zero operand needs no iteration: gcd is the other one.
                    if (bus.in_a == '0 || bus.in_b == '0) begin
                        result_d = bus.in_a | bus.in_b;
                        state_d  = DONE;
                    end else begin
                        state_d = (MODE == MODE_BIN) ? ALIGN : CALC;
                    end
                end
            end
            ALIGN: begin
                if (both_even) align   = 1'b1;
                else           state_d = CALC;
            end
            CALC: begin
                if (eq) begin
                    result_d = dp_result;
                    state_d  = DONE;
                end else begin
                    step = 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q == ALIGN) || (state_q == CALC);
    assign bus.out_gcd   = result_q;

`ifdef GCD_CYCLE_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The counter stops moving once DONE is reached, so it doubles as the
    // registered out_cycles value held until the result is taken.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE && bus.in_valid)
            cnt_d = '0;
        else if (bus.busy && cnt_q != '1)
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign bus.out_cycles = cnt_q;
`endif

endmodule

// File: tb/tb_gcd_unit.sv
// tb_gcd_unit: self-checking bench for gcd_unit, one instance per MODE.
// Expected results are queued when an operand pair is accepted and popped
// when the selected unit presents its result.
module tb_gcd_unit;
    localparam int WIDTH = 16;
`ifdef GCD_CYCLE_COUNT_EN
    localparam int CNT_W = 17;
`endif

    typedef struct {
        logic [WIDTH-1:0] g;
        int               cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic             sel;
    logic             drv_valid;
    logic             drv_ready;
    logic [WIDTH-1:0] drv_a;
    logic [WIDTH-1:0] drv_b;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

`ifdef GCD_CYCLE_COUNT_EN
    gcd_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) if_sub ();
    gcd_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) if_bin ();
    gcd_unit #(.WIDTH(WIDTH), .MODE(0), .CNT_W(CNT_W)) u_sub (.clk(clk), .rst(rst), .bus(if_sub));
    gcd_unit #(.WIDTH(WIDTH), .MODE(1), .CNT_W(CNT_W)) u_bin (.clk(clk), .rst(rst), .bus(if_bin));
`else
    gcd_if #(.WIDTH(WIDTH)) if_sub ();
    gcd_if #(.WIDTH(WIDTH)) if_bin ();
    gcd_unit #(.WIDTH(WIDTH), .MODE(0)) u_sub (.clk(clk), .rst(rst), .bus(if_sub));
    gcd_unit #(.WIDTH(WIDTH), .MODE(1)) u_bin (.clk(clk), .rst(rst), .bus(if_bin));
`endif

    assign if_sub.in_valid  = drv_valid & ~sel;
    assign if_bin.in_valid  = drv_valid & sel;
    assign if_sub.in_a      = drv_a;
    assign if_sub.in_b      = drv_b;
    assign if_bin.in_a      = drv_a;
    assign if_bin.in_b      = drv_b;
    assign if_sub.out_ready = drv_ready & ~sel;
    assign if_bin.out_ready = drv_ready & sel;

    logic             obs_in_ready, obs_valid, obs_busy;
    logic [WIDTH-1:0] obs_gcd;
    assign obs_in_ready = sel ? if_bin.in_ready  : if_sub.in_ready;
    assign obs_valid    = sel ? if_bin.out_valid : if_sub.out_valid;
    assign obs_busy     = sel ? if_bin.busy      : if_sub.busy;
    assign obs_gcd      = sel ? if_bin.out_gcd   : if_sub.out_gcd;
`ifdef GCD_CYCLE_COUNT_EN
    logic [CNT_W-1:0] obs_cycles;
    assign obs_cycles = sel ? if_bin.out_cycles : if_sub.out_cycles;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] gcd_ref(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] p, q, t;
        p = a;
        q = b;
        while (q != '0) begin
            t = p % q;
            p = q;
            q = t;
        end
        return p;
    endfunction

    // Present an operand pair and hold it until accepted; queue the expectation.
    task automatic start_op(input logic m, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic [WIDTH-1:0] g, input int cyc);
        exp_t e;
        int   n;
        sel       = m;
        drv_a     = a;
        drv_b     = b;
        drv_valid = 1'b1;
        n = 0;
        while (!obs_in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("accept_ready", obs_in_ready, 1);
        e.g   = g;
        e.cyc = cyc;
        exp_q.push_back(e);
        @(posedge clk); #1;
        drv_valid = 1'b0;
    endtask

    // Called one step after the accepting edge; lat counts edges from it.
    task automatic wait_result(input int lat);
        int n;
        n = 1;
        while (!obs_valid && n < 70000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("out_valid", obs_valid, 1);
        if (lat >= 0) chk("latency", n, lat);
    endtask

    task automatic take_result();
        exp_t e;
        if (exp_q.size() == 0) begin
            chk("queue_empty", 0, 1);
        end else begin
            e = exp_q.pop_front();
            chk("gcd", obs_gcd, e.g);
`ifdef GCD_CYCLE_COUNT_EN
            if (e.cyc >= 0) chk("cycles", obs_cycles, e.cyc);
`endif
        end
        chk("done_in_ready", obs_in_ready, 0);
        chk("done_busy", obs_busy, 0);
        drv_ready = 1'b1;
        @(posedge clk); #1;
        drv_ready = 1'b0;
        chk("release_valid", obs_valid, 0);
        chk("release_ready", obs_in_ready, 1);
    endtask

    task automatic run_op(input logic m, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] g, input int lat, input int cyc);
        start_op(m, a, b, g, cyc);
        wait_result(lat);
        take_result();
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] ra, rb;
        sel       = 1'b0;
        drv_ready = 1'b0;
        drv_a     = 16'd4;
        drv_b     = 16'd6;
        drv_valid = 1'b1;   // must be ignored while rst is high
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sub_valid", if_sub.out_valid, 0);
        chk("rst_sub_busy", if_sub.busy, 0);
        chk("rst_sub_ready", if_sub.in_ready, 1);
        chk("rst_sub_gcd", if_sub.out_gcd, 0);
        chk("rst_bin_valid", if_bin.out_valid, 0);
        chk("rst_bin_busy", if_bin.busy, 0);
        chk("rst_bin_ready", if_bin.in_ready, 1);
        chk("rst_bin_gcd", if_bin.out_gcd, 0);
`ifdef GCD_CYCLE_COUNT_EN
        chk("rst_sub_cycles", if_sub.out_cycles, 0);
        chk("rst_bin_cycles", if_bin.out_cycles, 0);
`endif
        drv_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_busy", if_sub.busy, 0);
        chk("post_rst_valid", if_sub.out_valid, 0);

        // Directed cases: mode, a, b, gcd, latency, cycles
        run_op(1'b0, 16'd12,    16'd18,    16'd6,     4,  3);
        run_op(1'b1, 16'd12,    16'd18,    16'd6,     6,  5);
        run_op(1'b1, 16'd48,    16'd180,   16'd12,    10, 9);
        run_op(1'b0, 16'd0,     16'd7,     16'd7,     1,  0);
        run_op(1'b1, 16'd0,     16'd0,     16'd0,     1,  0);
        run_op(1'b0, 16'd9,     16'd0,     16'd9,     1,  0);
        run_op(1'b0, 16'd7,     16'd7,     16'd7,     2,  1);
        run_op(1'b1, 16'd7,     16'd7,     16'd7,     3,  2);
        run_op(1'b0, 16'd21,    16'd6,     16'd3,     6,  5);
        run_op(1'b1, 16'd21,    16'd6,     16'd3,     6,  5);
        run_op(1'b1, 16'd32768, 16'd16384, 16'd16384, 18, 17);
        run_op(1'b0, 16'd1,     16'd65535, 16'd1,     65536, 65535);

        // Backpressure: result held, new request ignored while DONE.
        start_op(1'b0, 16'd36, 16'd24, 16'd12, 3);
        wait_result(4);
        drv_a     = 16'd100;
        drv_b     = 16'd75;
        drv_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", obs_valid, 1);
            chk("bp_gcd", obs_gcd, 12);
            chk("bp_in_ready", obs_in_ready, 0);
            chk("bp_busy", obs_busy, 0);
        end
        drv_valid = 1'b0;
        take_result();

        // Reset in the middle of CALC discards the operation.
        start_op(1'b0, 16'd1, 16'd1000, 16'd1, 999);
        repeat (5) @(posedge clk);
        #1;
        chk("pre_rst_busy", obs_busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", obs_valid, 0);
        chk("mid_rst_busy", obs_busy, 0);
        chk("mid_rst_ready", obs_in_ready, 1);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("after_rst_valid", obs_valid, 0);
        chk("after_rst_busy", obs_busy, 0);
        run_op(1'b0, 16'd21, 16'd6, 16'd3, 6, 5);

        // Small random operands, gcd from an independent reference.
        for (int i = 0; i < 16; i++) begin
            ra = WIDTH'($urandom_range(1, 255));
            rb = WIDTH'($urandom_range(1, 255));
            run_op(i[0], ra, rb, gcd_ref(ra, rb), -1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
